// File: rtl/addsub_ctrl_if.sv
// Handshake and control-word bundle between a sequencer client and addsub_ctrl.
// The master side requests sequences; the slave side emits the datapath control word and status.
interface addsub_ctrl_if;
    localparam int unsigned OP_W  = 3;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned E_W   = 5;

    logic             start;
    logic             mode;
    logic [OP_W-1:0]  op;
    logic [CNT_W-1:0] count;
    logic [E_W-1:0]   e;
    logic             busy;
    logic             done;

    modport master (output start, mode, op, count, input e, busy, done);
    modport slave  (input start, mode, op, count, output e, busy, done);
endinterface

// File: rtl/addsub_ctrl.sv
// Add/subtract sequencer: steps an accumulator datapath through a four-term
// sequence or a counted repeat, emitting the control word {ec, ebd, ea, er, emode}.
module addsub_ctrl (
    input  logic         clock,
    input  logic         reset,
    addsub_ctrl_if.slave bus
);
    localparam int unsigned OP_W  = 3;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned E_W   = 5;
    localparam int unsigned OUT_W = E_W + 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        TERM_B,
        TERM_C,
        TERM_D,
        REPEAT,
        FINISH
    } state_t;

    state_t             state;
    state_t             nxt;
    logic               mode_q;
    logic [OP_W-1:0]    op_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   cnt;
    logic [E_W-1:0]     e_q;
    logic               busy_q;
    logic               done_q;

    // Moore decode of {e, busy, done} for a given state.
    function automatic logic [OUT_W-1:0] moore(input state_t s, input logic [OP_W-1:0] o);
        logic [OUT_W-1:0] w;
        w = '0;
        case (s)
            LOAD:    w = {5'b00010, 1'b1, 1'b0};
            TERM_B:  w = {1'b0, 1'b0, 1'b1, 1'b1, o[0], 1'b1, 1'b0};
            TERM_C:  w = {1'b1, 1'b0, 1'b1, 1'b1, o[1], 1'b1, 1'b0};
            TERM_D:  w = {1'b0, 1'b1, 1'b1, 1'b1, o[2], 1'b1, 1'b0};
            REPEAT:  w = {1'b0, 1'b0, 1'b1, 1'b1, o[0], 1'b1, 1'b0};
            FINISH:  w = {5'b00000, 1'b0, 1'b1};
            default: w = '0;
        endcase
        return w;
    endfunction

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.start ? LOAD : IDLE;
            LOAD: begin
                if (!mode_q)
                    nxt = TERM_B;
                else if (count_q != '0)
                    nxt = REPEAT;
                else
                    nxt = FINISH;
            end
            TERM_B:  nxt = TERM_C;
            TERM_C:  nxt = TERM_D;
            TERM_D:  nxt = FINISH;
            // cnt holds the REPEAT cycles left including the current one
            REPEAT:  nxt = (cnt == CNT_W'(1)) ? FINISH : REPEAT;
            FINISH:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            mode_q  <= 1'b0;
            op_q    <= '0;
            count_q <= '0;
            cnt     <= '0;
            e_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state <= nxt;
            {e_q, busy_q, done_q} <= moore(nxt, op_q);
            if (state == IDLE && bus.start) begin
                mode_q  <= bus.mode;
                op_q    <= bus.op;
                count_q <= bus.count;
            end
            if (state == LOAD)
                cnt <= count_q;
            else if (state == REPEAT)
                cnt <= cnt - CNT_W'(1);
        end
    end

    assign bus.e    = e_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
